mem_copy_initiator: RTL and testbench

- Bus initiator for the data port of the 1024x16 unified memory (combinational read via mem_read, level-sensitive write via mem_write).
- On a start command it copies len consecutive words from src_adr to dst_adr, one read then one write per word.
- Sits beside the CPU datapath and drives the memory data-port signals while busy; the top level muxes CPU and copier onto the port using busy.

---
 rtl/mem_copy_pkg.sv | 27 ++
 rtl/mem_copy_if.sv | 36 +++
 rtl/mem_copy_addr_gen.sv | 65 ++++++
 rtl/mem_copy_initiator.sv | 141 ++++++++++++++
 tb/tb_mem_copy_initiator.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_copy_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_copy_pkg
// Brief    : Shared widths and FSM state encoding for the memory copy
//            initiator.
// Revision : 1.0 - initial release
// ============================================================================
package mem_copy_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 16;
  localparam int LEN_W_DEF  = 10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_FIN  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RD   = ST_RD,
    WR   = ST_WR,
    FIN  = ST_FIN
  } state_e;

endpackage
`default_nettype wire

// File: rtl/mem_copy_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_copy_if
// Brief    : Command and memory data-port bundle of the copy initiator.
//            master = initiator side, slave = commander/memory side.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_copy_if #(
  parameter int ADDR_W = mem_copy_pkg::ADDR_W_DEF,
  parameter int DATA_W = mem_copy_pkg::DATA_W_DEF,
  parameter int LEN_W  = mem_copy_pkg::LEN_W_DEF
);
  logic              start;
  logic [ADDR_W-1:0] src_adr;
  logic [ADDR_W-1:0] dst_adr;
  logic [LEN_W-1:0]  len;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] data_adr;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] data_mem_out;
  logic [DATA_W-1:0] checksum;

  modport master (
    input  start, src_adr, dst_adr, len, data_mem_out,
    output busy, done, data_adr, mem_read, mem_write, write_data, checksum
  );

  modport slave (
    output start, src_adr, dst_adr, len, data_mem_out,
    input  busy, done, data_adr, mem_read, mem_write, write_data, checksum
  );
endinterface
`default_nettype wire

// File: rtl/mem_copy_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : mem_copy_addr_gen
// Brief    : Holds the latched source/destination/length and the word index;
//            produces src+i, dst+i (modulo 2^ADDR_W) and the last-word flag.
// Revision : 1.0 - initial release
// ============================================================================
module mem_copy_addr_gen #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 10
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              load,
  input  wire logic              step,
  input  wire logic [ADDR_W-1:0] src_in,
  input  wire logic [ADDR_W-1:0] dst_in,
  input  wire logic [LEN_W-1:0]  len_in,
  output logic      [ADDR_W-1:0] src_adr,
  output logic      [ADDR_W-1:0] dst_adr,
  output logic                   last
);
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;

  // Latch transfer parameters on load; advance the index on step.
  always_comb begin
    src_d = src_q;
    dst_d = dst_q;
    len_d = len_q;
    idx_d = idx_q;
    if (load) begin
      src_d = src_in;
      dst_d = dst_in;
      len_d = len_in;
      idx_d = '0;
    end else if (step) begin
      idx_d = idx_q + LEN_W'(1);
    end
  end

  // Parameter and index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
      idx_q <= '0;
    end else begin
      src_q <= src_d;
      dst_q <= dst_d;
      len_q <= len_d;
      idx_q <= idx_d;
    end
  end

  // Additions wrap naturally at the address width.
  assign src_adr = src_q + ADDR_W'(idx_q);
  assign dst_adr = dst_q + ADDR_W'(idx_q);
  assign last    = (idx_q == (len_q - LEN_W'(1)));

endmodule
`default_nettype wire

// File: rtl/mem_copy_initiator.sv
`default_nettype none
// ============================================================================
// Module   : mem_copy_initiator
// Brief    : Copies len words from src_adr to dst_adr over the memory data
//            port, one read cycle then one write cycle per word.
//            Optional macro MEM_COPY_CHECKSUM_EN adds a running word sum of
//            everything read; without it checksum is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module mem_copy_initiator
  import mem_copy_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input wire logic  clk,
  input wire logic  rst_n,
  mem_copy_if.master bus
);
  state_e            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [DATA_W-1:0] buf_q, buf_d;

  logic              ag_load;
  logic              ag_step;
  logic              ag_last;
  logic [ADDR_W-1:0] ag_src;
  logic [ADDR_W-1:0] ag_dst;

  mem_copy_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (ag_load),
    .step    (ag_step),
    .src_in  (bus.src_adr),
    .dst_in  (bus.dst_adr),
    .len_in  (bus.len),
    .src_adr (ag_src),
    .dst_adr (ag_dst),
    .last    (ag_last)
  );

  // Next-state logic; strobe outputs are derived from the next state so they
  // are flops that line up exactly with the state register.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    ag_load = 1'b0;
    ag_step = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          ag_load = 1'b1;
          state_d = (bus.len == '0) ? FIN : RD;
        end
      end
      RD: begin
        buf_d   = bus.data_mem_out;
        state_d = WR;
      end
      WR: begin
        if (ag_last) begin
          state_d = FIN;
        end else begin
          ag_step = 1'b1;
          state_d = RD;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d      = (state_d == RD) || (state_d == WR);
    done_d      = (state_d == FIN);
    mem_read_d  = (state_d == RD);
    mem_write_d = (state_d == WR);
  end

  // State and registered outputs; reset drops mem_write immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      buf_q       <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      buf_q       <= buf_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_write  = mem_write_q;
  // Address and data only depend on flops, so they hold for the whole cycle.
  assign bus.data_adr   = mem_read_q  ? ag_src :
                          mem_write_q ? ag_dst : '0;
  assign bus.write_data = mem_write_q ? buf_q : '0;

`ifdef MEM_COPY_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q, checksum_d;

  // Clear on an accepted start, accumulate every word read, hold otherwise.
  always_comb begin
    checksum_d = checksum_q;
    if (ag_load) begin
      checksum_d = '0;
    end else if (state_q == RD) begin
      checksum_d = checksum_q + bus.data_mem_out;
    end
  end

  // Checksum register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign bus.checksum = checksum_q;
`else
  assign bus.checksum = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_copy_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_copy_initiator
// Brief    : Directed bench for mem_copy_initiator with a behavioural
//            1024x16 memory on the data port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_copy_initiator;
  localparam int AW = 10;
  localparam int DW = 16;
  localparam int LW = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_copy_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus ();

  mem_copy_initiator #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DW-1:0] mem [0:1023];
  int wr_cnt   = 0;
  int rd_cnt   = 0;
  int done_cnt = 0;
  int checks   = 0;
  int errors   = 0;

  assign bus.data_mem_out = mem[bus.data_adr];

  // Memory model: preload, then commit writes and count strobes at each edge.
  initial begin : mem_model
    for (int k = 0; k < 1024; k++) mem[k] = '0;
    for (int k = 0; k < 10; k++) mem[500 + k] = DW'(k + 1);
    mem[1022] = 16'hAAAA;
    mem[1023] = 16'hBBBB;
    mem[0]    = 16'h1111;
    mem[1]    = 16'h2222;
    forever begin
      @(posedge clk);
      if (bus.mem_write) begin
        mem[bus.data_adr] = bus.write_data;
        wr_cnt++;
      end
      if (bus.mem_read) rd_cnt++;
      if (bus.done) done_cnt++;
    end
  end

  typedef struct {
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [LW-1:0] len;
    int            lat;
    int            nwr;
    logic [DW-1:0] csum;
    int            ncmp;
    logic [DW-1:0] exp [10];
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Strobe start for one cycle; returns one step past the sampling edge.
  task automatic start_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW-1:0] l);
    bus.src_adr = s;
    bus.dst_adr = d;
    bus.len     = l;
    bus.start   = 1'b1;
    cyc();
    bus.start   = 1'b0;
  endtask

  // Cycles from the start edge until done is seen, bounded.
  task automatic wait_done(input int from, output int lat);
    lat = from;
    while (!bus.done && lat < 3000) begin
      cyc();
      lat++;
    end
  endtask

  function automatic logic [DW-1:0] exp_csum(input logic [DW-1:0] c);
`ifdef MEM_COPY_CHECKSUM_EN
    return c;
`else
    return c & '0;
`endif
  endfunction

  initial begin : main
    int lat;
    int wb;
    int rb;
    int db;
    logic [AW-1:0] a;

    // len=0: nothing read or written, mem[600] untouched.
    vecs[0].src = 500; vecs[0].dst = 600; vecs[0].len = 0;
    vecs[0].lat = 1;   vecs[0].nwr = 0;   vecs[0].csum = 16'd0; vecs[0].ncmp = 1;
    vecs[0].exp[0] = 16'd0;
    // Ten-word copy.
    vecs[1].src = 500; vecs[1].dst = 600; vecs[1].len = 10;
    vecs[1].lat = 21;  vecs[1].nwr = 10;  vecs[1].csum = 16'd55; vecs[1].ncmp = 10;
    for (int k = 0; k < 10; k++) vecs[1].exp[k] = DW'(k + 1);
    // Source address wraps 1023 -> 0.
    vecs[2].src = 1022; vecs[2].dst = 2; vecs[2].len = 4;
    vecs[2].lat = 9;    vecs[2].nwr = 4; vecs[2].csum = 16'h9998; vecs[2].ncmp = 4;
    vecs[2].exp[0] = 16'hAAAA; vecs[2].exp[1] = 16'hBBBB;
    vecs[2].exp[2] = 16'h1111; vecs[2].exp[3] = 16'h2222;
    // Overlap dst = src+1 propagates the first word.
    vecs[3].src = 500; vecs[3].dst = 501; vecs[3].len = 3;
    vecs[3].lat = 7;   vecs[3].nwr = 3;   vecs[3].csum = 16'd3; vecs[3].ncmp = 3;
    for (int k = 0; k < 3; k++) vecs[3].exp[k] = 16'd1;

    bus.start = 1'b0; bus.src_adr = '0; bus.dst_adr = '0; bus.len = '0;
    rst_n = 1'b0;
    repeat (3) cyc();
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_mem_rd_wr", {bus.mem_read, bus.mem_write}, 0);
    chk("rst_data_adr", bus.data_adr, 0);
    chk("rst_write_data", bus.write_data, 0);
    chk("rst_checksum", bus.checksum, 0);
    rst_n = 1'b1;
    repeat (2) cyc();

    for (int v = 0; v < 4; v++) begin
      wb = wr_cnt;
      rb = rd_cnt;
      db = done_cnt;
      start_copy(vecs[v].src, vecs[v].dst, vecs[v].len);
      chk($sformatf("v%0d_busy_c1", v), bus.busy, (vecs[v].len != 0));
      chk($sformatf("v%0d_read_c1", v), bus.mem_read, (vecs[v].len != 0));
      if (vecs[v].len != 0) chk($sformatf("v%0d_rd_adr", v), bus.data_adr, vecs[v].src);
      wait_done(1, lat);
      chk($sformatf("v%0d_latency", v), lat, vecs[v].lat);
      chk($sformatf("v%0d_busy_fin", v), bus.busy, 0);
      cyc();
      chk($sformatf("v%0d_done_1cyc", v), bus.done, 0);
      chk($sformatf("v%0d_writes", v), wr_cnt - wb, vecs[v].nwr);
      chk($sformatf("v%0d_reads", v), rd_cnt - rb, vecs[v].len);
      chk($sformatf("v%0d_dones", v), done_cnt - db, 1);
      chk($sformatf("v%0d_checksum", v), bus.checksum, exp_csum(vecs[v].csum));
      for (int k = 0; k < vecs[v].ncmp; k++) begin
        a = vecs[v].dst + AW'(k);
        chk($sformatf("v%0d_mem%0d", v, k), mem[a], vecs[v].exp[k]);
      end
    end

    // Second start three cycles into a copy must be ignored.
    wb = wr_cnt;
    db = done_cnt;
    start_copy(10'd600, 10'd700, 10'd10);
    cyc();
    cyc();
    bus.src_adr = 10'd0; bus.dst_adr = 10'd800; bus.len = 10'd1; bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    wait_done(4, lat);
    chk("ign_latency", lat, 21);
    repeat (5) cyc();
    chk("ign_dones", done_cnt - db, 1);
    chk("ign_writes", wr_cnt - wb, 10);
    chk("ign_mem800", mem[800], 0);
    chk("ign_checksum", bus.checksum, exp_csum(16'd55));
    for (int k = 0; k < 10; k++) chk($sformatf("ign_mem%0d", 700 + k), mem[700 + k], k + 1);

    // Reset during the write cycle of word 3.
    wb = wr_cnt;
    start_copy(10'd600, 10'd900, 10'd10);
    repeat (7) cyc();
    chk("rst_mid_wr", bus.mem_write, 1);
    chk("rst_mid_adr", bus.data_adr, 903);
    rst_n = 1'b0;
    #1;
    chk("rst_async_wr", bus.mem_write, 0);
    chk("rst_async_busy", bus.busy, 0);
    chk("rst_async_adr", bus.data_adr, 0);
    cyc();
    rst_n = 1'b1;
    repeat (4) cyc();
    chk("rst_post_busy", bus.busy, 0);
    chk("rst_post_rdwr", {bus.mem_read, bus.mem_write}, 0);
    chk("rst_post_writes", wr_cnt - wb, 3);
    for (int k = 0; k < 3; k++) chk($sformatf("rst_mem%0d", 900 + k), mem[900 + k], k + 1);
    chk("rst_mem903", mem[903], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
